// File: rtl/my9262_pkg.sv
// Shared types and widths for the MY9262 grayscale frame buffer.
package my9262_pkg;

    localparam int unsigned GRAY_W_DEF  = 16;
    localparam int unsigned NUM_CH_DEF  = 16;
    localparam int unsigned DIM_W       = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/my9262_gray_bank.sv
// Two NUM_CH x GRAY_W gray banks: host writes the back bank (!sel), the streamer reads the front (sel).
module my9262_gray_bank
    import my9262_pkg::*;
#(
    parameter int unsigned GRAY_W = GRAY_W_DEF,
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [GRAY_W-1:0] wr_data,
    input  logic [CH_W-1:0]   rd_idx,
    output logic [GRAY_W-1:0] front_data,
    output logic [GRAY_W-1:0] back_data
);

    logic [GRAY_W-1:0] bank0 [NUM_CH];
    logic [GRAY_W-1:0] bank1 [NUM_CH];
    logic              wr_ok_c;

    // Out-of-range channels are dropped (only reachable when NUM_CH is not a power of two).
    assign wr_ok_c = ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else if (wr_en && wr_ok_c) begin
            if (sel) bank0[wr_ch] <= wr_data;
            else     bank1[wr_ch] <= wr_data;
        end
    end

    assign front_data = sel ? bank1[rd_idx] : bank0[rd_idx];
    assign back_data  = sel ? bank0[rd_idx] : bank1[rd_idx];

endmodule

// File: rtl/my9262_gray_buf.sv
// Double-buffered gray frame store feeding the MY9262 serializer, highest channel first.
// Optional global dimming stage enabled by defining MY9262_DIM_EN.
module my9262_gray_buf
    import my9262_pkg::*;
#(
    parameter int unsigned GRAY_W = GRAY_W_DEF,
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
    input  logic                   CLK_200M,
    input  logic                   RST,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [CH_W-1:0]        wr_ch,
    input  logic [GRAY_W-1:0]      wr_data,
    input  logic                   swap_req,
    output logic                   swap_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [GRAY_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   lat_req,
    input  logic                   lat_done,
`ifdef MY9262_DIM_EN
    input  logic [DIM_W-1:0]       dim,
`endif
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0] NEXT_CH = CH_W'(NUM_CH - 2);

    state_t            state;
    logic              sel;
    logic              pending;
    logic              pending_nx_c;
    logic              commit_c;
    logic              issue_left;
    logic [CH_W-1:0]   idx;
    logic [CH_W-1:0]   rd_idx_c;
    logic [GRAY_W-1:0] front_rd;
    logic [GRAY_W-1:0] back_rd;
    logic [GRAY_W-1:0] first_word_c;
    logic              w_valid;
    logic              w_last;
    logic [GRAY_W-1:0] w_data;
    logic              w_adv_c;
    logic              last_hs_c;

    assign wr_ready = 1'b1;

    my9262_gray_bank #(
        .GRAY_W (GRAY_W),
        .NUM_CH (NUM_CH)
    ) u_bank (
        .clk        (CLK_200M),
        .rst        (RST),
        .sel        (sel),
        .wr_en      (wr_valid),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx_c),
        .front_data (front_rd),
        .back_data  (back_rd)
    );

    assign commit_c     = (state == ST_IDLE) && pending;
    assign pending_nx_c = swap_req || (pending && !commit_c);
    assign rd_idx_c     = (state == ST_IDLE) ? LAST_CH : idx;
    // A write landing on the commit edge goes into the new front bank, so forward it.
    assign first_word_c = (wr_valid && (wr_ch == LAST_CH)) ? wr_data : back_rd;

`ifdef MY9262_DIM_EN
    localparam int unsigned PROD_W = GRAY_W + DIM_W + 1;

    logic              o_valid;
    logic              o_last;
    logic [GRAY_W-1:0] o_data;
    logic              o_adv_c;
    logic [PROD_W-1:0] prod_c;

    assign o_adv_c   = !o_valid || out_ready;
    assign w_adv_c   = !w_valid || o_adv_c;
    assign prod_c    = PROD_W'(w_data) * PROD_W'({1'b0, dim} + (DIM_W+1)'(1));
    assign last_hs_c = o_valid && out_ready && o_last;

    // Scaling stage advances only when its output slot frees up.
    always_ff @(posedge CLK_200M or posedge RST) begin
        if (RST) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else if (o_adv_c) begin
            o_valid <= w_valid;
            o_last  <= w_last;
            o_data  <= GRAY_W'(prod_c >> DIM_W);
        end
    end

    assign out_valid = o_valid;
    assign out_last  = o_last;
    assign out_data  = o_data;
`else
    assign w_adv_c   = !w_valid || out_ready;
    assign last_hs_c = w_valid && out_ready && w_last;
    assign out_valid = w_valid;
    assign out_last  = w_last;
    assign out_data  = w_data;
`endif

    // Frame FSM: commit swap, issue words NUM_CH-1..0, then request a latch.
    always_ff @(posedge CLK_200M or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            pending    <= 1'b0;
            idx        <= '0;
            issue_left <= 1'b0;
            w_valid    <= 1'b0;
            w_last     <= 1'b0;
            w_data     <= '0;
            lat_req    <= 1'b0;
            frame_cnt  <= '0;
            swap_busy  <= 1'b0;
        end else begin
            pending <= pending_nx_c;
            lat_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        sel        <= !sel;
                        idx        <= NEXT_CH;
                        issue_left <= 1'b1;
                        w_valid    <= 1'b1;
                        w_last     <= 1'b0;
                        w_data     <= first_word_c;
                        state      <= ST_STREAM;
                        swap_busy  <= 1'b1;
                    end else begin
                        swap_busy  <= pending_nx_c;
                    end
                end
                ST_STREAM: begin
                    swap_busy <= 1'b1;
                    if (w_adv_c) begin
                        if (issue_left) begin
                            w_valid    <= 1'b1;
                            w_data     <= front_rd;
                            w_last     <= (idx == '0);
                            issue_left <= (idx != '0);
                            idx        <= idx - CH_W'(1);
                        end else begin
                            w_valid    <= 1'b0;
                        end
                    end
                    if (last_hs_c) begin
                        state   <= ST_LATCH;
                        lat_req <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (lat_done) begin
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        state     <= ST_IDLE;
                        swap_busy <= pending_nx_c;
                    end else begin
                        swap_busy <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
